// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and config record for the cordic rotator and its phase front end.
// No logic of its own; no latency or backpressure.
// Amplitude clamp keeps the rotator gain (~1.647) from overflowing AMP_W.
package cordic_pkg;

    localparam int PHASE_W    = 32;
    localparam int AMP_W      = 16;
    localparam int AMP_MAX    = 19429;
    localparam int CORDIC_LAT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    typedef struct packed {
        logic [PHASE_W-1:0] fcw;
        logic [PHASE_W-1:0] sweep;
        logic [PHASE_W-1:0] poff;
        logic [AMP_W-1:0]   amp;
    } cfg_t;

    function automatic logic [AMP_W-1:0] clamp_amp(input logic [AMP_W-1:0] a);
        return (a > AMP_W'(AMP_MAX)) ? AMP_W'(AMP_MAX) : a;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth valid shift register aligning sample valids with the rotator output.
// Latency: DEPTH clocks. No backpressure; shifts every clock.
// Async active-low clear empties the pipe.
module valid_delay_line #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe <= {pipe[DEPTH-2:0], d};
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase accumulator with fcw/sweep/offset feeding the cordic angle/xin/yin inputs.
// Latency: angle one clock after the sampling edge; cordic_valid CORDIC_LAT clocks later.
// Backpressure: cfg_ready low while a shadow config waits for the next accumulator wrap.
module cordic_phase_gen
    import cordic_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_fcw,
    input  logic [PHASE_W-1:0] cfg_sweep,
    input  logic [PHASE_W-1:0] cfg_poff,
    input  logic [AMP_W-1:0]   cfg_amp,
    output logic [PHASE_W-1:0] angle,
    output logic [AMP_W-1:0]   xin,
    output logic [AMP_W-1:0]   yin,
    output logic               angle_valid,
    output logic               wrap,
    output logic               cordic_valid
);

    state_t             state, state_nxt;
    cfg_t               act, shd, cfg_in;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W:0]   acc_sum;
    logic               carry_q;
    logic               cfg_xfer;
    logic               step;

    assign cfg_ready = (state != PEND);
    assign cfg_xfer  = cfg_valid && cfg_ready;
    assign step      = (state != IDLE) && enable;
    assign acc_sum   = {1'b0, acc} + {1'b0, act.fcw};
    assign cfg_in    = '{fcw: cfg_fcw, sweep: cfg_sweep, poff: cfg_poff, amp: clamp_amp(cfg_amp)};
    assign yin       = '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) state_nxt = RUN;
            RUN: begin
                if (!enable)       state_nxt = IDLE;
                else if (cfg_xfer) state_nxt = PEND;
            end
            PEND: begin
                if (!enable)                state_nxt = IDLE;
                else if (acc_sum[PHASE_W]) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act         <= '0;
            shd         <= '0;
            acc         <= '0;
            carry_q     <= 1'b0;
            angle       <= '0;
            xin         <= '0;
            wrap        <= 1'b0;
            angle_valid <= 1'b0;
        end else begin
            angle_valid <= step;
            if (step) begin
                angle   <= acc + act.poff;
                acc     <= acc_sum[PHASE_W-1:0];
                carry_q <= acc_sum[PHASE_W];
                wrap    <= carry_q;
                xin     <= act.amp;
                act.fcw <= act.fcw + act.sweep;
            end else begin
                wrap <= 1'b0;
            end

            // Config writes come last so a shadow copy overrides the fcw sweep update.
            case (state)
                IDLE: begin
                    if (cfg_xfer) begin
                        act     <= cfg_in;
                        acc     <= '0;
                        carry_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (cfg_xfer) begin
                        if (enable) shd <= cfg_in;
                        else        act <= cfg_in;
                    end
                end
                PEND: begin
                    if (!enable || acc_sum[PHASE_W]) act <= shd;
                end
                default: ;
            endcase
        end
    end

    valid_delay_line #(.DEPTH(CORDIC_LAT)) u_vld_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (angle_valid),
        .q     (cordic_valid)
    );

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Self-checking bench: closed-form phase model (acc_n = n*fcw + sweep*n(n-1)/2) plus directed scenarios.
module tb_cordic_phase_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_fcw = '0, cfg_sweep = '0, cfg_poff = '0;
    logic [15:0] cfg_amp = '0;
    logic [31:0] angle;
    logic [15:0] xin, yin;
    logic        angle_valid, wrap, cordic_valid;

    int total = 0;
    int bad   = 0;

    cordic_phase_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_fcw      (cfg_fcw),
        .cfg_sweep    (cfg_sweep),
        .cfg_poff     (cfg_poff),
        .cfg_amp      (cfg_amp),
        .angle        (angle),
        .xin          (xin),
        .yin          (yin),
        .angle_valid  (angle_valid),
        .wrap         (wrap),
        .cordic_valid (cordic_valid)
    );

    always #5 clk = ~clk;

    // Accumulator value before sample n of a run started from acc=0.
    function automatic logic [31:0] acc_at(input logic [31:0] f, input logic [31:0] s, input int n);
        logic [63:0] t;
        t = 64'(n) * 64'(f) + 64'(s) * 64'((n * (n - 1)) / 2);
        return t[31:0];
    endfunction

    // Sample n is a wrap sample if producing acc_n overflowed 2^32.
    function automatic logic wrap_at(input logic [31:0] f, input logic [31:0] s, input int n);
        logic [32:0] sum;
        if (n == 0) return 1'b0;
        sum = {1'b0, acc_at(f, s, n - 1)} + {1'b0, f + 32'(n - 1) * s};
        return sum[32];
    endfunction

    function automatic logic [15:0] amp_model(input logic [15:0] a);
        return (a > 16'd19429) ? 16'd19429 : a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic cfg_idle(input logic [31:0] f, input logic [31:0] s, input logic [31:0] p,
                            input logic [15:0] a, input logic en);
        cfg_valid = 1'b1; cfg_fcw = f; cfg_sweep = s; cfg_poff = p; cfg_amp = a; enable = en;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
        tick();
        total++; if (angle !== 32'h0) begin bad++; $display("FAIL reset_angle got=%h want=0", angle); end
        total++; if (xin !== 16'h0) begin bad++; $display("FAIL reset_xin got=%h want=0", xin); end
        total++; if (yin !== 16'h0) begin bad++; $display("FAIL reset_yin got=%h want=0", yin); end
        total++; if (angle_valid !== 1'b0) begin bad++; $display("FAIL reset_angle_valid got=%b want=0", angle_valid); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", wrap); end
        total++; if (cordic_valid !== 1'b0) begin bad++; $display("FAIL reset_cordic_valid got=%b want=0", cordic_valid); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%b want=1", cfg_ready); end
        rst_n = 1'b1;
        tick();
        total++; if (angle_valid !== 1'b0) begin bad++; $display("FAIL idle_angle_valid got=%b want=0", angle_valid); end
    endtask

    task automatic test_step();
        logic        hist [0:47];
        logic [31:0] exp5 [0:4] = '{32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0};
        logic [31:0] want;
        int n = 0, first_av = -1, first_cv = -1;
        do_reset();
        cfg_idle(32'h4000_0000, 32'h0, 32'h0, 16'd1000, 1'b1);
        for (int i = 0; i < 48; i++) begin
            tick();
            total++;
            if (cordic_valid !== (i >= 16 ? hist[i-16] : 1'b0)) begin
                bad++; $display("FAIL step_cordic_valid cyc=%0d got=%b", i, cordic_valid);
            end
            hist[i] = angle_valid;
            if (angle_valid && first_av < 0) first_av = i;
            if (cordic_valid && first_cv < 0) first_cv = i;
            if (angle_valid) begin
                want = (n < 5) ? exp5[n] : acc_at(32'h4000_0000, 32'h0, n);
                total++; if (angle !== want) begin bad++; $display("FAIL step_angle n=%0d got=%h want=%h", n, angle, want); end
                total++; if (wrap !== (n == 4 || (n > 4 && wrap_at(32'h4000_0000, 32'h0, n)))) begin
                    bad++; $display("FAIL step_wrap n=%0d got=%b", n, wrap);
                end
                n++;
            end
        end
        total++; if (first_cv - first_av != 16) begin
            bad++; $display("FAIL step_cordic_lat got=%0d want=16", first_cv - first_av);
        end
    endtask

    task automatic test_offset();
        int n = 0;
        do_reset();
        cfg_idle(32'h0, 32'h0, 32'h2000_0000, 16'd32000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (angle_valid) begin
                total++; if (angle !== 32'h2000_0000) begin bad++; $display("FAIL offset_angle got=%h want=20000000", angle); end
                total++; if (xin !== 16'd19429) begin bad++; $display("FAIL offset_xin got=%0d want=19429", xin); end
                total++; if (yin !== 16'd0) begin bad++; $display("FAIL offset_yin got=%0d want=0", yin); end
                n++;
            end
        end
        total++; if (n != 6) begin bad++; $display("FAIL offset_count got=%0d want=6", n); end
    endtask

    task automatic test_sweep();
        logic [31:0] exp5 [0:4] = '{32'h0, 32'h0, 32'h0100_0000, 32'h0300_0000, 32'h0600_0000};
        int n = 0;
        do_reset();
        cfg_idle(32'h0, 32'h0100_0000, 32'h0, 16'd5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (!angle_valid || angle !== exp5[n]) begin
                bad++; $display("FAIL sweep_angle n=%0d got=%h want=%h vld=%b", n, angle, exp5[n], angle_valid);
            end
            n++;
        end
    endtask

    task automatic test_random();
        logic [31:0] f, s, p, want;
        logic [15:0] a;
        int n;
        for (int it = 0; it < 6; it++) begin
            f = $urandom; s = (it % 2 == 0) ? 32'h0 : $urandom; p = $urandom;
            a = (it % 3 == 0) ? 16'($urandom_range(19430, 65535)) : 16'($urandom_range(0, 19429));
            n = 0;
            do_reset();
            cfg_idle(f, s, p, a, 1'b1);
            for (int i = 0; i < 20; i++) begin
                tick();
                want = acc_at(f, s, n) + p;
                total++; if (angle !== want) begin bad++; $display("FAIL rand_angle it=%0d n=%0d got=%h want=%h", it, n, angle, want); end
                total++; if (wrap !== wrap_at(f, s, n)) begin bad++; $display("FAIL rand_wrap it=%0d n=%0d got=%b", it, n, wrap); end
                total++; if (xin !== amp_model(a)) begin bad++; $display("FAIL rand_xin it=%0d got=%0d want=%0d", it, xin, amp_model(a)); end
                n++;
            end
        end
    endtask

    task automatic test_phase_update();
        do_reset();
        cfg_idle(32'h4000_0000, 32'h0, 32'h0, 16'd100, 1'b1);
        tick();
        total++; if (angle !== 32'h0) begin bad++; $display("FAIL upd_a0 got=%h want=0", angle); end
        tick();
        total++; if (angle !== 32'h4000_0000) begin bad++; $display("FAIL upd_a1 got=%h want=40000000", angle); end
        cfg_valid = 1'b1; cfg_fcw = 32'h6AAA_AAAA; cfg_sweep = '0; cfg_poff = '0; cfg_amp = 16'd200;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL upd_ready_before got=%b want=1", cfg_ready); end
        tick();
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL upd_ready_drop got=%b want=0", cfg_ready); end
        total++; if (angle !== 32'h8000_0000) begin bad++; $display("FAIL upd_a2 got=%h want=80000000", angle); end
        cfg_fcw = 32'h1111_1111; cfg_amp = 16'd300;
        tick();
        cfg_valid = 1'b0;
        total++; if (angle !== 32'hC000_0000) begin bad++; $display("FAIL upd_a3 got=%h want=c0000000", angle); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL upd_ready_rise got=%b want=1", cfg_ready); end
        tick();
        total++; if (angle !== 32'h0 || wrap !== 1'b1) begin bad++; $display("FAIL upd_wrap_sample got=%h/%b want=0/1", angle, wrap); end
        total++; if (xin !== 16'd200) begin bad++; $display("FAIL upd_xin got=%0d want=200", xin); end
        tick();
        total++; if (angle !== 32'h6AAA_AAAA) begin bad++; $display("FAIL upd_a5 got=%h want=6aaaaaaa", angle); end
        tick();
        total++; if (angle !== 32'hD555_5554) begin bad++; $display("FAIL upd_a6 got=%h want=d5555554", angle); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL upd_ready_end got=%b want=1", cfg_ready); end
    endtask

    task automatic test_pause();
        logic        hist [0:63];
        logic [31:0] last, want;
        int n = 0, idle_cnt = 0;
        do_reset();
        cfg_idle(32'h1000_0000, 32'h0, 32'h0500_0000, 16'd500, 1'b1);
        last = '0;
        for (int i = 0; i < 64; i++) begin
            enable = !(i >= 8 && i <= 12);
            tick();
            total++;
            if (cordic_valid !== (i >= 16 ? hist[i-16] : 1'b0)) begin
                bad++; $display("FAIL pause_cordic_valid cyc=%0d got=%b", i, cordic_valid);
            end
            hist[i] = angle_valid;
            if (angle_valid) begin
                want = acc_at(32'h1000_0000, 32'h0, n) + 32'h0500_0000;
                total++; if (angle !== want) begin bad++; $display("FAIL pause_angle n=%0d got=%h want=%h", n, angle, want); end
                last = angle;
                n++;
            end else begin
                idle_cnt++;
                total++; if (angle !== last) begin bad++; $display("FAIL pause_hold cyc=%0d got=%h want=%h", i, angle, last); end
            end
        end
        total++; if (idle_cnt != 6) begin bad++; $display("FAIL pause_idle_cycles got=%0d want=6", idle_cnt); end
    endtask

    task automatic test_reset_pend();
        int nv = 0;
        do_reset();
        cfg_idle(32'h4000_0000, 32'h0, 32'h0300_0000, 16'd700, 1'b1);
        repeat (2) tick();
        cfg_valid = 1'b1; cfg_fcw = 32'h1234_5678; cfg_poff = 32'h0700_0000; cfg_amp = 16'd900;
        tick();
        cfg_valid = 1'b0;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rpend_in_pend got=%b want=0", cfg_ready); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (angle !== 32'h0 || xin !== 16'h0 || wrap !== 1'b0) begin
            bad++; $display("FAIL rpend_async_data got=%h/%h/%b want=0", angle, xin, wrap);
        end
        total++; if (angle_valid !== 1'b0 || cordic_valid !== 1'b0) begin
            bad++; $display("FAIL rpend_async_valid got=%b/%b want=0", angle_valid, cordic_valid);
        end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rpend_async_ready got=%b want=1", cfg_ready); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (angle_valid) begin
                nv++;
                total++; if (angle !== 32'h0 || xin !== 16'h0) begin
                    bad++; $display("FAIL rpend_shadow_dropped got=%h/%0d want=0/0", angle, xin);
                end
            end
        end
        total++; if (nv == 0) begin bad++; $display("FAIL rpend_resume got=%0d samples want>0", nv); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_offset();
        test_sweep();
        test_random();
        test_phase_update();
        test_pause();
        test_reset_pend();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
